// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - classifies a debounced button level into press/release/short/long/repeat pulses
// Optional double-click detection is compiled in with `define BTN_DCLICK_EN.
module btn_event_decoder #(
  parameter int TICK_DIV     = 100_000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int DCLICK_TICKS = 300
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_held,
  output logic o_double
);

  localparam int HOLD_MAX_LR = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HOLD_MAX    = (HOLD_MAX_LR > DCLICK_TICKS) ? HOLD_MAX_LR : DCLICK_TICKS;
  localparam int HOLD_W      = $clog2(HOLD_MAX + 1);
  localparam int TICK_W      = $clog2(TICK_DIV);

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT    = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_TICKS - 1);
`ifdef BTN_DCLICK_EN
  localparam logic [HOLD_W-1:0] DCLICK_LAST = HOLD_W'(DCLICK_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD,
    S_WAIT2,
    S_DBL_HELD
  } state_t;

  state_t              state_q, state_d;
  logic                btn_q;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                tick, rise, fall, hold_clr;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                short_q, short_d;
  logic                long_q, long_d;
  logic                repeat_q, repeat_d;
`ifdef BTN_DCLICK_EN
  logic                double_q, double_d;
`endif

  // Free-running tick base; deliberately independent of button activity.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  assign rise = i_btn & ~btn_q;
  assign fall = ~i_btn & btn_q;

  // Timers expire on the tick that brings the hold counter up to its target.
  always_comb begin
    state_d   = state_q;
    hold_clr  = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
`ifdef BTN_DCLICK_EN
    double_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
`ifdef BTN_DCLICK_EN
          state_d   = S_WAIT2;
`else
          short_d   = 1'b1;
          state_d   = S_IDLE;
`endif
        end else if (tick && hold_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_LONG_HELD;
        end
      end
      S_LONG_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
        end else if (tick && hold_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          hold_clr = 1'b1;
        end
      end
`ifdef BTN_DCLICK_EN
      S_WAIT2: begin
        if (rise) begin
          press_d  = 1'b1;
          double_d = 1'b1;
          state_d  = S_DBL_HELD;
        end else if (tick && hold_q == DCLICK_LAST) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DBL_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) hold_clr = 1'b1;
  end

  always_comb begin
    if (hold_clr) begin
      hold_d = '0;
    end else if (tick && hold_q != HOLD_SAT) begin
      hold_d = hold_q + HOLD_W'(1);
    end else begin
      hold_d = hold_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      btn_q      <= 1'b0;
      tick_cnt_q <= '0;
      hold_q     <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
`ifdef BTN_DCLICK_EN
      double_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      btn_q      <= i_btn;
      tick_cnt_q <= tick_cnt_d;
      hold_q     <= hold_d;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
`ifdef BTN_DCLICK_EN
      double_q   <= double_d;
`endif
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_short   = short_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_held    = btn_q;
`ifdef BTN_DCLICK_EN
  assign o_double  = double_q;
`else
  assign o_double  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - scoreboard bench for btn_event_decoder
// Expectations follow BTN_DCLICK_EN when the bench is built with it.
module tb_btn_event_decoder;

  localparam int TICK_DIV     = 4;
  localparam int LONG_TICKS   = 10;
  localparam int REPEAT_TICKS = 3;
  localparam int DCLICK_TICKS = 5;

  localparam int K_PRESS   = 0;
  localparam int K_DOUBLE  = 1;
  localparam int K_RELEASE = 2;
  localparam int K_SHORT   = 3;
  localparam int K_LONG    = 4;
  localparam int K_REPEAT  = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic i_btn = 1'b0;
  logic o_press, o_release, o_short, o_long, o_repeat, o_held, o_double;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int prev_cyc = 0;
  int tb_tcnt = 0;

  typedef struct {
    int kind;
    int lo;
    int hi;
    bit rel;
  } exp_t;

  exp_t exp_q[$];

  btn_event_decoder #(
    .TICK_DIV     (TICK_DIV),
    .LONG_TICKS   (LONG_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS),
    .DCLICK_TICKS (DCLICK_TICKS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_btn     (i_btn),
    .o_press   (o_press),
    .o_release (o_release),
    .o_short   (o_short),
    .o_long    (o_long),
    .o_repeat  (o_repeat),
    .o_held    (o_held),
    .o_double  (o_double)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference tick phase: counts 0..TICK_DIV-1 from reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_tcnt <= 0;
    else          tb_tcnt <= (tb_tcnt == TICK_DIV - 1) ? 0 : tb_tcnt + 1;
  end

  function automatic string kind_name(int k);
    case (k)
      K_PRESS:   return "press";
      K_DOUBLE:  return "double";
      K_RELEASE: return "release";
      K_SHORT:   return "short";
      K_LONG:    return "long";
      default:   return "repeat";
    endcase
  endfunction

  function automatic void push_exp(int kind, int lo, int hi, bit rel);
    exp_t e;
    e.kind = kind;
    e.lo   = lo;
    e.hi   = hi;
    e.rel  = rel;
    exp_q.push_back(e);
  endfunction

  // Every observed pulse pops the next expectation and is compared against it.
  always @(negedge clk) begin
    logic [5:0] p;
    exp_t e;
    int lo;
    int hi;
    p = {o_repeat, o_long, o_short, o_release, o_double, o_press};
    for (int k = 0; k < 6; k++) begin
      if (p[k]) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_%s: pulse at cycle %0d, required none", kind_name(k), cyc);
        end else begin
          e  = exp_q.pop_front();
          lo = e.rel ? prev_cyc + e.lo : e.lo;
          hi = e.rel ? prev_cyc + e.hi : e.hi;
          if (e.kind !== k || cyc < lo || cyc > hi) begin
            n_fail++;
            $display("FAIL event_%s: got %s at cycle %0d, required %s in cycles %0d..%0d",
                     kind_name(e.kind), kind_name(k), cyc, kind_name(e.kind), lo, hi);
          end
        end
        prev_cyc = cyc;
      end
    end
  end

  task automatic test_reset();
    logic [6:0] outs;
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      outs = {o_press, o_release, o_short, o_long, o_repeat, o_held, o_double};
      n_tests++;
      if (outs !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_hold: outputs %b, required 0000000", outs);
      end
      i_btn = ~i_btn;
    end
    i_btn   = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      outs = {o_press, o_release, o_short, o_long, o_repeat, o_held, o_double};
      n_tests++;
      if (outs !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_release: outputs %b, required 0000000", outs);
      end
    end
  endtask

  task automatic test_short_click();
    int c;
    @(negedge clk);
    c = cyc;
    i_btn = 1'b1;
    push_exp(K_PRESS, c + 1, c + 1, 1'b0);
    repeat (10) @(negedge clk);
    n_tests++;
    if (o_held !== 1'b1) begin
      n_fail++;
      $display("FAIL short_held: o_held=%b, required 1", o_held);
    end
    repeat (10) @(negedge clk);
    i_btn = 1'b0;
    push_exp(K_RELEASE, c + 21, c + 21, 1'b0);
`ifdef BTN_DCLICK_EN
    push_exp(K_SHORT, 16, 20, 1'b1);
`else
    push_exp(K_SHORT, c + 21, c + 21, 1'b0);
`endif
    repeat (2) @(negedge clk);
    n_tests++;
    if (o_held !== 1'b0) begin
      n_fail++;
      $display("FAIL short_unheld: o_held=%b, required 0", o_held);
    end
    repeat (30) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL short_click_missing: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single_click();
    int c;
    @(negedge clk);
    c = cyc;
    i_btn = 1'b1;
    push_exp(K_PRESS, c + 1, c + 1, 1'b0);
    repeat (8) @(negedge clk);
    i_btn = 1'b0;
    push_exp(K_RELEASE, c + 9, c + 9, 1'b0);
`ifdef BTN_DCLICK_EN
    push_exp(K_SHORT, 16, 20, 1'b1);
`else
    push_exp(K_SHORT, c + 9, c + 9, 1'b0);
`endif
    repeat (30) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_click_missing: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_long_hold();
    int c;
    @(negedge clk);
    c = cyc;
    i_btn = 1'b1;
    push_exp(K_PRESS, c + 1, c + 1, 1'b0);
    push_exp(K_LONG, 36, 40, 1'b1);
    for (int i = 0; i < 3; i++) push_exp(K_REPEAT, 12, 12, 1'b1);
    repeat (80) @(negedge clk);
    i_btn = 1'b0;
    push_exp(K_RELEASE, c + 81, c + 81, 1'b0);
    repeat (30) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL long_hold_missing: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Press lands on a tick edge, so the tenth tick after it is exactly 40 cycles later.
  task automatic test_boundary();
    int c;
    int guard;
    for (int hold = 40; hold <= 41; hold++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (tb_tcnt != TICK_DIV - 1 && guard < 2 * TICK_DIV);
      c = cyc;
      i_btn = 1'b1;
      push_exp(K_PRESS, c + 1, c + 1, 1'b0);
      if (hold == 41) push_exp(K_LONG, c + 41, c + 41, 1'b0);
      repeat (hold) @(negedge clk);
      i_btn = 1'b0;
      push_exp(K_RELEASE, c + hold + 1, c + hold + 1, 1'b0);
      if (hold == 40) begin
`ifdef BTN_DCLICK_EN
        push_exp(K_SHORT, 16, 20, 1'b1);
`else
        push_exp(K_SHORT, c + 41, c + 41, 1'b0);
`endif
      end
      repeat (30) @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL boundary_%0d_missing: %0d events outstanding, required 0", hold, exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic test_reset_high();
    int c;
    @(negedge clk);
    reset_n = 1'b0;
    i_btn = 1'b1;
    repeat (3) @(negedge clk);
    c = cyc;
    reset_n = 1'b1;
    push_exp(K_PRESS, c + 1, c + 1, 1'b0);
    repeat (5) @(negedge clk);
    i_btn = 1'b0;
    push_exp(K_RELEASE, c + 6, c + 6, 1'b0);
`ifdef BTN_DCLICK_EN
    push_exp(K_SHORT, 16, 20, 1'b1);
`else
    push_exp(K_SHORT, c + 6, c + 6, 1'b0);
`endif
    repeat (30) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_high_missing: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Two 1-cycle presses separated by a 2-cycle gap.
  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    c = cyc;
    i_btn = 1'b1;
    push_exp(K_PRESS, c + 1, c + 1, 1'b0);
    @(negedge clk);
    i_btn = 1'b0;
    push_exp(K_RELEASE, c + 2, c + 2, 1'b0);
`ifndef BTN_DCLICK_EN
    push_exp(K_SHORT, c + 2, c + 2, 1'b0);
`endif
    repeat (2) @(negedge clk);
    i_btn = 1'b1;
    push_exp(K_PRESS, c + 4, c + 4, 1'b0);
`ifdef BTN_DCLICK_EN
    push_exp(K_DOUBLE, c + 4, c + 4, 1'b0);
`endif
    @(negedge clk);
    i_btn = 1'b0;
    push_exp(K_RELEASE, c + 5, c + 5, 1'b0);
`ifndef BTN_DCLICK_EN
    push_exp(K_SHORT, c + 5, c + 5, 1'b0);
`endif
    repeat (30) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back_missing: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_double_click();
    int c;
    @(negedge clk);
    c = cyc;
    i_btn = 1'b1;
    push_exp(K_PRESS, c + 1, c + 1, 1'b0);
    repeat (8) @(negedge clk);
    i_btn = 1'b0;
    push_exp(K_RELEASE, c + 9, c + 9, 1'b0);
`ifndef BTN_DCLICK_EN
    push_exp(K_SHORT, c + 9, c + 9, 1'b0);
`endif
    repeat (8) @(negedge clk);
    i_btn = 1'b1;
    push_exp(K_PRESS, c + 17, c + 17, 1'b0);
`ifdef BTN_DCLICK_EN
    push_exp(K_DOUBLE, c + 17, c + 17, 1'b0);
`endif
    repeat (8) @(negedge clk);
    i_btn = 1'b0;
    push_exp(K_RELEASE, c + 25, c + 25, 1'b0);
`ifndef BTN_DCLICK_EN
    push_exp(K_SHORT, c + 25, c + 25, 1'b0);
`endif
    repeat (30) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL double_click_missing: %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_short_click();
    test_single_click();
    test_long_hold();
    test_boundary();
    test_reset_high();
    test_back_to_back();
    test_double_click();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
